// File: rtl/pc_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : pc_redirect_unit_pkg
// Brief  : State encoding and shared constants for the PC redirect unit.
// Rev    : 1.0  initial release
// ============================================================================
package pc_redirect_unit_pkg;

   localparam logic [1:0] c_ST_BOOT = 2'd0;
   localparam logic [1:0] c_ST_RUN  = 2'd1;
   localparam logic [1:0] c_ST_PEND = 2'd2;

   typedef enum logic [1:0] {
      ST_BOOT = c_ST_BOOT,
      ST_RUN  = c_ST_RUN,
      ST_PEND = c_ST_PEND
   } pcState_t;

   localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

   // Low address bits that are forced to zero on every redirect target
   localparam logic [1:0]  c_ALIGN_LSB_MASK   = 2'b11;

endpackage : pc_redirect_unit_pkg
`default_nettype wire

// File: rtl/pc_redirect_unit_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module : pc_next_mux
// Brief  : Priority redirect select (taken branch > jr > jump) with word align.
// Rev    : 1.0  initial release
// ============================================================================
module pc_next_mux
   import pc_redirect_unit_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic            BranchValid,
   input  logic            BranchFlag,
   input  logic [PC_W-1:0] BranchTarget,
   input  logic            JrValid,
   input  logic [PC_W-1:0] JrTarget,
   input  logic            JumpValid,
   input  logic [PC_W-1:0] JumpTarget,
   output logic [PC_W-1:0] Target,
   output logic            Redirect,
   output logic            TakenBranch
);

   localparam logic [PC_W-1:0] c_ALIGN_MASK = ~{{(PC_W-2){1'b0}}, c_ALIGN_LSB_MASK};

   logic [PC_W-1:0] w_sel;

   always_comb begin
      w_sel       = '0;
      Redirect    = 1'b0;
      TakenBranch = BranchValid & BranchFlag;
      // A taken branch means the ID-stage jr/jump is on the wrong path
      if (TakenBranch) begin
         w_sel    = BranchTarget;
         Redirect = 1'b1;
      end else if (JrValid) begin
         w_sel    = JrTarget;
         Redirect = 1'b1;
      end else if (JumpValid) begin
         w_sel    = JumpTarget;
         Redirect = 1'b1;
      end
   end

   assign Target = w_sel & c_ALIGN_MASK;

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module : pc_redirect_unit
// Brief  : PC register, redirect FSM and pipeline flush strobes.
// Rev    : 1.0  initial release
// ============================================================================
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(c_RESET_PC_DEFAULT)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Stall,
   input  logic            BranchValid,
   input  logic            BranchFlag,
   input  logic [PC_W-1:0] BranchTarget,
   input  logic            JrValid,
   input  logic [PC_W-1:0] JrTarget,
   input  logic            JumpValid,
   input  logic [PC_W-1:0] JumpTarget,
   output logic [PC_W-1:0] PC,
   output logic [PC_W-1:0] PCPlus4,
   output logic            FetchValid,
   output logic            FlushIFID,
   output logic            FlushIDEX,
   output logic            RedirectPending
);

   pcState_t        r_state;
   pcState_t        w_nextState;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_pendTarget;
   logic [PC_W-1:0] w_pcNext;
   logic [PC_W-1:0] w_pendNext;
   logic [PC_W-1:0] w_pcPlus4;
   logic [PC_W-1:0] w_target;
   logic            w_redirect;
   logic            w_taken;

   assign w_pcPlus4 = r_pc + PC_W'(4);
   assign PC        = r_pc;
   assign PCPlus4   = w_pcPlus4;

   pc_next_mux #(
      .PC_W         (PC_W)
   ) u_pcNextMux (
      .BranchValid  (BranchValid),
      .BranchFlag   (BranchFlag),
      .BranchTarget (BranchTarget),
      .JrValid      (JrValid),
      .JrTarget     (JrTarget),
      .JumpValid    (JumpValid),
      .JumpTarget   (JumpTarget),
      .Target       (w_target),
      .Redirect     (w_redirect),
      .TakenBranch  (w_taken)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_pendTarget <= '0;
      end else begin
         r_state      <= w_nextState;
         r_pc         <= w_pcNext;
         r_pendTarget <= w_pendNext;
      end
   end

   always_comb begin
      w_nextState     = r_state;
      w_pcNext        = r_pc;
      w_pendNext      = r_pendTarget;
      FetchValid      = 1'b0;
      FlushIFID       = 1'b0;
      FlushIDEX       = 1'b0;
      RedirectPending = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_nextState = ST_RUN;
         end
         ST_RUN: begin
            FetchValid = 1'b1;
            FlushIFID  = w_redirect;
            FlushIDEX  = w_taken;
            if (!Stall) begin
               w_pcNext = w_redirect ? w_target : w_pcPlus4;
            end else if (w_redirect) begin
               w_pendNext  = w_target;
               w_nextState = ST_PEND;
            end
         end
         ST_PEND: begin
            // Held fetch is wrong-path; new requests belong to flushed slots
            FetchValid      = 1'b1;
            FlushIFID       = 1'b1;
            RedirectPending = 1'b1;
            if (!Stall) begin
               w_pcNext    = r_pendTarget;
               w_nextState = ST_RUN;
            end
         end
         default: begin
            w_nextState = ST_BOOT;
         end
      endcase
   end

endmodule : pc_redirect_unit
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_redirect_unit
// Brief  : Scoreboard bench for pc_redirect_unit against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pc_redirect_unit;

   localparam int          PC_W     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Stall = 1'b0;
   logic        BranchValid = 1'b0;
   logic        BranchFlag = 1'b0;
   logic [31:0] BranchTarget = '0;
   logic        JrValid = 1'b0;
   logic [31:0] JrTarget = '0;
   logic        JumpValid = 1'b0;
   logic [31:0] JumpTarget = '0;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        FetchValid;
   logic        FlushIFID;
   logic        FlushIDEX;
   logic        RedirectPending;

   pc_redirect_unit #(
      .PC_W            (PC_W),
      .RESET_PC        (RESET_PC)
   ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Stall           (Stall),
      .BranchValid     (BranchValid),
      .BranchFlag      (BranchFlag),
      .BranchTarget    (BranchTarget),
      .JrValid         (JrValid),
      .JrTarget        (JrTarget),
      .JumpValid       (JumpValid),
      .JumpTarget      (JumpTarget),
      .PC              (PC),
      .PCPlus4         (PCPlus4),
      .FetchValid      (FetchValid),
      .FlushIFID       (FlushIFID),
      .FlushIDEX       (FlushIDEX),
      .RedirectPending (RedirectPending)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pcPlus4;
      logic        fv;
      logic        fi;
      logic        fx;
      logic        rp;
   } expect_t;

   expect_t q[$];
   int      vectors = 0;
   int      miscompares = 0;

   // Reference model: "fresh out of reset", "a redirect is waiting", fetch address
   bit          mBooting = 1'b1;
   bit          mWaiting = 1'b0;
   logic [31:0] mWaitAddr = '0;
   logic [31:0] mPc = RESET_PC;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, wanted %h", name, $time, act, req);
      end
   endtask

   always @(negedge Clk) begin
      if (q.size() > 0) begin
         expect_t e;
         e = q.pop_front();
         check("PC", PC, e.pc);
         check("PCPlus4", PCPlus4, e.pcPlus4);
         check("FetchValid", 32'(FetchValid), 32'(e.fv));
         check("FlushIFID", 32'(FlushIFID), 32'(e.fi));
         check("FlushIDEX", 32'(FlushIDEX), 32'(e.fx));
         check("RedirectPending", 32'(RedirectPending), 32'(e.rp));
      end
   end

   task automatic step(input bit rstn, input bit st,
                       input bit bv, input bit bf, input logic [31:0] bt,
                       input bit jrv, input logic [31:0] jrt,
                       input bit jv, input logic [31:0] jt);
      expect_t     e;
      bit          wants;
      logic [31:0] dest;
      @(posedge Clk);
      #1;
      Reset = rstn; Stall = st;
      BranchValid = bv; BranchFlag = bf; BranchTarget = bt;
      JrValid = jrv; JrTarget = jrt; JumpValid = jv; JumpTarget = jt;

      if (!rstn) begin
         mBooting = 1'b1; mWaiting = 1'b0; mWaitAddr = '0; mPc = RESET_PC;
      end
      e.pc = mPc; e.pcPlus4 = mPc + 32'd4;
      e.fv = 1'b0; e.fi = 1'b0; e.fx = 1'b0; e.rp = 1'b0;

      if (!rstn) begin
         // outputs already at reset values
      end else if (mBooting) begin
         mBooting = 1'b0;
      end else if (mWaiting) begin
         e.fv = 1'b1; e.fi = 1'b1; e.rp = 1'b1;
         if (!st) begin
            mPc = mWaitAddr;
            mWaiting = 1'b0;
         end
      end else begin
         wants = 1'b1;
         if (bv && bf)  dest = bt;
         else if (jrv)  dest = jrt;
         else if (jv)   dest = jt;
         else begin     dest = '0; wants = 1'b0; end
         dest = (dest / 4) * 4;
         e.fv = 1'b1;
         e.fi = wants;
         e.fx = bv && bf;
         if (!st) mPc = wants ? dest : mPc + 32'd4;
         else if (wants) begin
            mWaiting = 1'b1;
            mWaitAddr = dest;
         end
      end
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, 0, '0, 0, '0);
   endtask

   initial begin
      // Reset release and sequential fetch
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, 0, '0, 0, '0);
      idle(4);
      // Taken branch from 0x10
      step(1, 0, 0, 0, '0, 0, '0, 1, 32'h10);
      step(1, 0, 1, 1, 32'h40, 0, '0, 0, '0);
      idle(1);
      // Not-taken branch with jump, then taken branch beats jump
      step(1, 0, 1, 0, 32'h80, 0, '0, 1, 32'h100);
      step(1, 0, 1, 1, 32'h80, 0, '0, 1, 32'h100);
      idle(1);
      // Redirect resolved under a three-cycle stall
      step(1, 1, 1, 1, 32'h2C, 0, '0, 0, '0);
      step(1, 1, 1, 1, 32'h300, 1, 32'h400, 0, '0);
      step(1, 1, 0, 0, '0, 0, '0, 1, 32'h500);
      step(1, 0, 0, 0, '0, 0, '0, 1, 32'h600);
      idle(2);
      // Alignment and address wrap
      step(1, 0, 0, 0, '0, 1, 32'h123, 0, '0);
      step(1, 0, 0, 0, '0, 0, '0, 1, 32'hFFFF_FFFE);
      idle(3);
      // Reset while a redirect is pending
      step(1, 1, 0, 0, '0, 0, '0, 1, 32'h200);
      step(1, 1, 0, 0, '0, 0, '0, 0, '0);
      step(0, 1, 0, 0, '0, 0, '0, 0, '0);
      step(1, 0, 0, 0, '0, 0, '0, 0, '0);
      idle(4);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit rs;
         logic [31:0] bt, jrt, jt;
         rs  = ($urandom_range(0, 199) != 0);
         bt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
         jrt = $urandom;
         jt  = $urandom_range(0, 4095);
         step(rs, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, bt,
              $urandom_range(0, 9) < 2, jrt,
              $urandom_range(0, 9) < 2, jt);
      end
      idle(2);
      @(negedge Clk);
      @(negedge Clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard drain: %0d entries left, wanted 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pc_redirect_unit
`default_nettype wire

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Program-counter register and redirect controller that sits directly downstream of the EX-stage branch comparator. It consumes the comparator's BranchFlag, together with jump and jump-register requests from ID, and selects the next PC. It generates the IF/ID and ID/EX flush strobes. A redirect that resolves while the front end is stalled is buffered and applied when the stall releases.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_W, 32, PC and target width

Ports:
Clk  in  1  system clock; all state updates on rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
Stall  in  1  hazard-unit hold; PC and IF/ID must not advance
BranchValid  in  1  conditional branch instruction present in EX
BranchFlag  in  1  comparator result for that branch (1 = taken)
BranchTarget  in  PC_W  EX-computed branch target
JrValid  in  1  jr/jalr resolved in ID
JrTarget  in  PC_W  register target for jr
JumpValid  in  1  j/jal decoded in ID
JumpTarget  in  PC_W  pseudo-direct jump target
PC  out  PC_W  current fetch address
PCPlus4  out  PC_W  PC + 4 (modulo 2^PC_W)
FetchValid  out  1  instruction memory output is valid to latch into IF/ID
FlushIFID  out  1  clear IF/ID (overrides Stall in that register)
FlushIDEX  out  1  clear ID/EX
RedirectPending  out  1  buffered redirect awaiting stall release

Behaviour:
- Reset (async, Reset=0) values: PC=RESET_PC, state=BOOT, pending target=0, FetchValid=0, FlushIFID=0, FlushIDEX=0, RedirectPending=0.
- States: BOOT, RUN, PEND.
- BOOT: lasts one cycle after reset deasserts. PC holds, FetchValid=0, all requests are ignored. Next state is RUN.
- RUN, redirect priority: taken branch (BranchValid&BranchFlag) > JrValid > JumpValid > sequential PC+4.
- Taken branch: FlushIFID=1 and FlushIDEX=1 combinationally, in the same cycle.
- Jr/Jump: FlushIFID=1 only. A taken branch in the same cycle suppresses the jr/jump, because that instruction is on the wrong path.
- RUN, Stall=0: PC <= selected target, or PC+4 if there is no redirect.
- RUN, Stall=1, no redirect: PC holds.
- RUN, Stall=1, with redirect: PC holds. The selected target is latched into the pending register, the next state is PEND, and the flushes are still asserted in this cycle.
- PEND: RedirectPending=1 and FlushIFID=1 every cycle, because the held fetch is wrong-path. BranchValid, JrValid and JumpValid are ignored, because those instructions are flushed.
  - Stall=1: remain in PEND.
  - Stall=0: PC <= pending target, next state is RUN. RedirectPending stays 1 through this cycle and clears in the next cycle.
- FetchValid = 1 in RUN and PEND.
- Latency: a redirect is visible on PC one cycle after the resolving cycle when Stall=0.
- Targets are forced word-aligned: bits [1:0] are zeroed before being loaded into PC or the pending register.
- PC+4 wraps modulo 2^PC_W (0xFFFF_FFFC -> 0x0000_0000), with no flag.
- BranchFlag is don't-care when BranchValid=0. FlushIDEX is never asserted without a taken branch.
- Reset asserted mid-PEND discards the pending target immediately.
- Flush outputs are combinational from state and inputs. PC, the pending register and state are registered.

Decomposition:
- Shared package: state encoding (BOOT, RUN, PEND as 2-bit localparams), RESET_PC default, word-align mask constant.
- One natural sub-module: pc_next_mux. It is the combinational priority select plus alignment, producing the target and a redirect-valid signal. The FSM and registers stay in the top.

Test Plan:
- Reset release: hold Reset=0 three cycles, then release -> PC=0x0 for BOOT plus one cycle with FetchValid 0 then 1; PC sequence 0x0, 0x4, 0x8.
- Taken branch, no stall: PC=0x10, BranchValid=1, BranchFlag=1, BranchTarget=0x40 -> FlushIFID=FlushIDEX=1 that cycle; next PC=0x40.
- Not-taken plus simultaneous jump: BranchValid=1, BranchFlag=0, JumpValid=1, JumpTarget=0x100 -> FlushIFID=1, FlushIDEX=0, next PC=0x100. Repeat with BranchFlag=1 and BranchTarget=0x80 -> next PC=0x80.
- Redirect under stall: Stall=1 for 3 cycles, taken branch to 0x2C in the first -> PC held, RedirectPending=1 and FlushIFID=1 for the stall cycles; on release, PC=0x2C and RedirectPending clears the cycle after.
- Alignment and wrap: JrTarget=0x123 -> PC=0x120. Force PC=0xFFFF_FFFC with no redirect -> next PC=0x0.
- Reset mid-PEND: enter PEND with target 0x200, assert Reset -> PC=RESET_PC immediately and RedirectPending=0; after release, 0x200 is never fetched.
